spiflash_wb_reader: RTL

Wishbone classic slave that serves 32-bit read-only accesses directly from an external SPI NOR flash, for execute-in-place boot code and constant data. Each Wishbone read issues one READ (0x03) command, shifts in 4 bytes and acknowledges with the assembled word. It sits on the SoC Wishbone bus and drives the spi0 pins, as the initiator opposite the flash responder.

---
 rtl/spiflash_wb_pkg.sv | 23 ++
 rtl/spi_sclk_gen.sv | 40 ++++
 rtl/spiflash_wb_reader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spiflash_wb_pkg.sv
// Shared constants, state encoding and helpers for the SPI flash Wishbone reader.
package spiflash_wb_pkg;

  localparam logic [7:0] READ_OPCODE    = 8'h03;
  localparam int         FRAME_BITS     = 64;
  localparam logic [5:0] LAST_BIT       = 6'(FRAME_BITS - 1);
  localparam logic [5:0] DATA_START_BIT = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_ACK      = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  // First byte off the wire lands in the least significant byte of the word.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Mode-0 SCLK divider: level output plus strobes marking the edge on which SCLK rises or falls.
module spi_sclk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_r;
  logic       sclk_r;
  logic       wrap_s;

  assign wrap_s = en && (div_r == DIV_LAST);
  assign rise   = wrap_s && !sclk_r;
  assign fall   = wrap_s && sclk_r;
  assign sclk   = sclk_r;

  // Half-period counter; SCLK parks low whenever the generator is disabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_r  <= 8'd0;
      sclk_r <= 1'b0;
    end else if (!en) begin
      div_r  <= 8'd0;
      sclk_r <= 1'b0;
    end else if (wrap_s) begin
      div_r  <= 8'd0;
      sclk_r <= ~sclk_r;
    end else begin
      div_r  <= div_r + 8'd1;
    end
  end

endmodule

// File: rtl/spiflash_wb_reader.sv
// Wishbone classic read-only slave fetching each 32-bit word from SPI NOR flash with one READ command.
module spiflash_wb_reader
  import spiflash_wb_pkg::*;
#(
  parameter int CLK_DIV        = 1,
  parameter int ADDR_BITS      = 24,
  parameter int CS_HIGH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] wb_adr_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_HIGH_CYCLES - 1);

  state_t      state_r, state_s;
  logic [7:0]  wait_r;
  logic [5:0]  bit_r;
  logic [63:0] tx_r;
  logic [31:0] rx_r;
  logic [31:0] dat_r;
  logic        cs_r, mosi_r, ack_r, err_r;
  logic        sclk_en_s, rise_s, fall_s, sclk_s;
  logic        req_s, frame_done_s, wait_done_s;
  logic [7:0]  wait_last_s;
  logic        unused_s;

  assign unused_s     = ^{wb_sel_i, wb_adr_i[31:ADDR_BITS], wb_adr_i[1:0]};
  assign req_s        = wb_cyc_i & wb_stb_i;
  assign sclk_en_s    = (state_r == ST_SHIFT);
  assign frame_done_s = fall_s && (bit_r == LAST_BIT);
  assign wait_last_s  = (state_r == ST_GAP) ? GAP_LAST : DIV_LAST;
  assign wait_done_s  = (wait_r == wait_last_s);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (sclk_en_s),
    .sclk    (sclk_s),
    .rise    (rise_s),
    .fall    (fall_s)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; writes skip the flash and go straight to the CS gap.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s && wb_we_i) state_s = ST_GAP;
        else if (req_s)       state_s = ST_CS_SETUP;
        else                  state_s = ST_IDLE;
      end
      ST_CS_SETUP: begin
        if (wait_done_s) state_s = ST_SHIFT;
        else             state_s = ST_CS_SETUP;
      end
      ST_SHIFT: begin
        if (frame_done_s) state_s = ST_CS_HOLD;
        else              state_s = ST_SHIFT;
      end
      ST_CS_HOLD: begin
        if (wait_done_s) state_s = ST_ACK;
        else             state_s = ST_CS_HOLD;
      end
      ST_ACK:  state_s = ST_GAP;
      ST_GAP: begin
        if (wait_done_s) state_s = ST_IDLE;
        else             state_s = ST_GAP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath: shift registers, bit counter, wait counter and registered bus/pin outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_r <= 8'd0;
      bit_r  <= 6'd0;
      tx_r   <= 64'd0;
      rx_r   <= 32'd0;
      dat_r  <= 32'd0;
      cs_r   <= 1'b1;
      mosi_r <= 1'b0;
      ack_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      if (state_s != state_r) wait_r <= 8'd0;
      else                    wait_r <= wait_r + 8'd1;
      case (state_r)
        ST_IDLE: begin
          if (req_s && wb_we_i) begin
            err_r <= 1'b1;
          end else if (req_s) begin
            tx_r   <= {READ_OPCODE, wb_adr_i[ADDR_BITS-1:2], 2'b00, 32'd0};
            mosi_r <= READ_OPCODE[7];
            cs_r   <= 1'b0;
            bit_r  <= 6'd0;
          end
        end
        ST_SHIFT: begin
          if (rise_s && (bit_r >= DATA_START_BIT)) begin
            rx_r <= {rx_r[30:0], spi_miso};
          end
          if (fall_s) begin
            bit_r  <= bit_r + 6'd1;
            tx_r   <= {tx_r[62:0], 1'b0};
            mosi_r <= tx_r[62];
          end
        end
        ST_CS_HOLD: begin
          // An abandoned cycle still finishes the frame but its word is dropped.
          if (wait_done_s) begin
            cs_r <= 1'b1;
            if (req_s) begin
              ack_r <= 1'b1;
              dat_r <= byte_swap(rx_r);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign wb_dat_o = dat_r;
  assign wb_ack_o = ack_r;
  assign wb_err_o = err_r;
  assign spi_cs   = cs_r;
  assign spi_sclk = sclk_s;
  assign spi_mosi = mosi_r;

endmodule
